// File: rtl/sram_arb_2to1_if.sv
// rtl/sram_arb_2to1_if.sv - instruction, data and SRAM bus bundle for the 2:1 SRAM arbiter
interface sram_arb_2to1_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  // Arbiter side
  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  // Core ports plus SRAM model side
  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/sram_arb_2to1.sv
// rtl/sram_arb_2to1.sv - 2:1 instr/data SRAM arbiter, one-cycle responses; SRAM_ARB_STARVE_GUARD_EN enables data starvation guard
module sram_arb_2to1 #(
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter logic [31:0] MemMask  = 32'h0000_FFFF,
  parameter int unsigned MaxStall = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  sram_arb_2to1_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRspI = 2'd1;
  localparam logic [1:0] StRspD = 2'd2;
  localparam logic [3:0] StallMax = MaxStall[3:0];

  logic       instr_in_range;
  logic       data_in_range;
  logic       starve;
  logic       instr_win;
  logic       data_win;
  logic       win_in_range;
  logic       mem_req;
  logic [1:0] state_q;
  logic       err_q;
  logic       we_q;
  logic       instr_rvalid;
  logic       data_rvalid;

  assign instr_in_range = (bus.instr_addr_i & ~MemMask) == MemStart;
  assign data_in_range  = (bus.data_addr_i  & ~MemMask) == MemStart;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  logic [3:0] stall_q;

  assign starve = (stall_q == StallMax) && bus.data_req_i;

  // Count consecutive cycles the data port asks and loses; saturates so the guard stays armed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= 4'd0;
    end else if (bus.data_req_i && !data_win) begin
      if (stall_q != StallMax) begin
        stall_q <= stall_q + 4'd1;
      end
    end else begin
      stall_q <= 4'd0;
    end
  end
`else
  logic unused_stall_max;

  assign unused_stall_max = ^StallMax;
  assign starve           = 1'b0;
`endif

  // Grants are gated by reset so nothing leaks out while rst_ni is low
  assign instr_win    = rst_ni && bus.instr_req_i && !starve;
  assign data_win     = rst_ni && bus.data_req_i && !instr_win;
  assign win_in_range = instr_win ? instr_in_range : data_in_range;
  assign mem_req      = (instr_win || data_win) && win_in_range;

  assign bus.instr_gnt_o = instr_win;
  assign bus.data_gnt_o  = data_win;

  // SRAM fields are zero unless an in-range access is actually issued
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_req && data_win && bus.data_we_i;
  assign bus.mem_be_o    = (mem_req && data_win) ? bus.data_be_i : 4'd0;
  assign bus.mem_wdata_o = (mem_req && data_win) ? bus.data_wdata_i : 32'd0;
  assign bus.mem_addr_o  = !mem_req ? 32'd0 :
                           instr_win ? bus.instr_addr_i : bus.data_addr_i;

  // Response FSM: every grant is answered exactly one cycle later; reset drops a pending answer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else if (instr_win) begin
      state_q <= StRspI;
      err_q   <= !instr_in_range;
      we_q    <= 1'b0;
    end else if (data_win) begin
      state_q <= StRspD;
      err_q   <= !data_in_range;
      we_q    <= bus.data_we_i;
    end else begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end
  end

  assign instr_rvalid = (state_q == StRspI);
  assign data_rvalid  = (state_q == StRspD);

  assign bus.instr_rvalid_o = instr_rvalid;
  assign bus.instr_err_o    = instr_rvalid && err_q;
  assign bus.instr_rdata_o  = (instr_rvalid && !err_q) ? bus.mem_rdata_i : 32'd0;

  // Stores and errored accesses return zero data; only loads forward the SRAM word
  assign bus.data_rvalid_o  = data_rvalid;
  assign bus.data_err_o     = data_rvalid && err_q;
  assign bus.data_rdata_o   = (data_rvalid && !err_q && !we_q) ? bus.mem_rdata_i : 32'd0;

endmodule

// File: doc/sram_arb_2to1.md
SRAM_ARB_2TO1 -- requirements
Module: sram_arb_2to1

Interface
REQ-001 Parameter MemStart, 32'h00000000, base address of the SRAM window.
REQ-002 Parameter MemMask, 32'h0000FFFF, window mask; an address is in range when (addr & ~MemMask) == MemStart.
REQ-003 Parameter MaxStall, 4, consecutive denied data-request cycles before data wins (range 1..15).
REQ-004 clk_i  input  1  system clock; all flops on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 instr_req_i  input  1  instruction fetch request.
REQ-007 instr_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 instr_rvalid_o  output  1  fetch response valid.
REQ-009 instr_addr_i  input  32  fetch byte address.
REQ-010 instr_rdata_o  output  32  fetch read data.
REQ-011 instr_err_o  output  1  fetch bus error, valid with instr_rvalid_o.
REQ-012 data_req_i  input  1  load/store request.
REQ-013 data_gnt_o  output  1  load/store accepted this cycle.
REQ-014 data_rvalid_o  output  1  load/store response valid (loads and stores).
REQ-015 data_we_i  input  1  1 = store.
REQ-016 data_be_i  input  4  byte enables.
REQ-017 data_addr_i  input  32  load/store byte address.
REQ-018 data_wdata_i  input  32  store data.
REQ-019 data_rdata_o  output  32  load data.
REQ-020 data_err_o  output  1  load/store bus error, valid with data_rvalid_o.
REQ-021 mem_req_o  output  1  SRAM access strobe.
REQ-022 mem_we_o  output  1  SRAM write enable.
REQ-023 mem_be_o  output  4  SRAM byte enables.
REQ-024 mem_addr_o  output  32  SRAM byte address.
REQ-025 mem_wdata_o  output  32  SRAM write data.
REQ-026 mem_rdata_i  input  32  SRAM read data, valid one cycle after mem_req_o.

Function
REQ-027 Winner per cycle: instr if instr_req_i and starve guard inactive; else data if data_req_i; else none.
REQ-028 Grant is combinational, same cycle as request: winner's gnt_o = 1, loser's gnt_o = 0; at most one gnt_o high per cycle.
REQ-029 mem_req_o = 1 only when a winner exists and its address is in range; mem_* fields carry the winner's signals, else all zero; mem_we_o/mem_be_o/mem_wdata_o zero for instr winner.
REQ-030 Response FSM states IDLE, RSP_I, RSP_D, plus registered err flag; any grant moves to RSP_I/RSP_D (err = out-of-range), no grant moves to IDLE.
REQ-031 Latency fixed at one cycle: in RSP_x, x_rvalid_o = 1, x_rdata_o = mem_rdata_i (zero when err), x_err_o = err; other requester's rvalid/err/rdata = 0.
REQ-032 Back-to-back: grant in an RSP cycle is legal; FSM goes directly RSP_x -> RSP_y; full throughput of one transfer per cycle.
REQ-033 Out-of-range request: granted, no SRAM access, rvalid with err = 1 and rdata = 0 next cycle.
REQ-034 Stores also produce data_rvalid_o one cycle after grant, rdata = 0.
REQ-035 Stall counter (4 bit): increments when data_req_i high and data_gnt_o low, saturates at MaxStall, clears on data grant or data_req_i low.
REQ-036 Starve guard active when stall counter == MaxStall and data_req_i high; data then wins over a simultaneous instr request.

Reset
REQ-037 Asserting rst_ni forces FSM IDLE, err 0, stall counter 0 immediately; a response pending at reset is dropped, no rvalid issued.
REQ-038 While rst_ni low: all gnt_o, rvalid_o, err_o, mem_req_o, mem_we_o = 0; all rdata_o, mem_* buses = 0.

Configuration
REQ-039 Macro SRAM_ARB_STARVE_GUARD_EN defined: REQ-035/036 implemented as stated.
REQ-040 Macro undefined: no stall counter, strict instr priority; data granted only when instr_req_i low; MaxStall ignored.

Verification
REQ-041 instr_req_i=1 addr 0x80 alone -> instr_gnt_o=1 same cycle, mem_addr_o=0x80; next cycle instr_rvalid_o=1, rdata=mem_rdata_i, err=0.
REQ-042 data store addr 0x1000 be=4'b0011 wdata=0xDEADBEEF -> mem_we_o=1, mem_be_o=0011; next cycle data_rvalid_o=1, rdata=0.
REQ-043 data load addr 0x0002_0000 -> data_gnt_o=1, mem_req_o=0; next cycle data_rvalid_o=1, data_err_o=1, rdata=0.
REQ-044 instr and data both held high, MaxStall=4, guard enabled -> instr granted cycles 0-3, data granted cycle 4, counter cleared; guard disabled -> data never granted.
REQ-045 alternating instr/data grants on consecutive cycles -> rvalid alternates every cycle, no response lost or misrouted.
REQ-046 rst_ni low in the cycle after a grant -> no rvalid on either port; after release FSM IDLE, next request served normally.
